// File: rtl/seq_divider_if.sv
// seq_divider_if: start/busy/done handshake bundle for the sequential divider.
//   start    - request strobe (master -> divider)
//   numer    - signed dividend, sampled with start
//   denom    - signed divisor, sampled with start
//   busy     - operation in progress (divider -> master)
//   done     - one-cycle completion pulse
//   quotient - signed quotient, truncated toward zero
//   remain   - signed remainder, sign follows the dividend
//   divzero  - last completed operation had a zero divisor
interface seq_divider_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] numer;
    logic [WIDTH-1:0] denom;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remain;
    logic             divzero;

    modport master (
        output start, numer, denom,
        input  busy, done, quotient, remain, divzero
    );

    modport slave (
        input  start, numer, denom,
        output busy, done, quotient, remain, divzero
    );
endinterface

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle signed divider using a restoring shift-subtract
// loop, one quotient bit per clock. Fixed latency of WIDTH+2 clocks from the
// accepted start to the done pulse, including divide-by-zero.
// Ports:
//   clock - system clock, rising edge
//   reset - synchronous, active-high; aborts any operation in progress
//   bus   - seq_divider_if slave modport (start/numer/denom in,
//           busy/done/quotient/remain/divzero out)
module seq_divider #(
    parameter int WIDTH = 16
) (
    input  logic          clock,
    input  logic          reset,
    seq_divider_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    // Unsigned magnitude of a two's-complement value; the most negative value
    // maps onto itself, which is exact when read as unsigned.
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
        if (v[WIDTH-1]) begin
            abs_val = {WIDTH{1'b0}} - v;
        end else begin
            abs_val = v;
        end
    endfunction

    // Conditional two's-complement negation.
    function automatic logic [WIDTH-1:0] neg_if(input logic             neg,
                                                input logic [WIDTH-1:0] v);
        if (neg) begin
            neg_if = {WIDTH{1'b0}} - v;
        end else begin
            neg_if = v;
        end
    endfunction

    state_t           state_q,   state_d;
    logic [CW-1:0]    cnt_q,     cnt_d;
    logic [WIDTH:0]   prem_q,    prem_d;     // partial remainder, WIDTH+1 bits
    logic [WIDTH-1:0] dvd_q,     dvd_d;      // dividend bits out, quotient bits in
    logic [WIDTH-1:0] dsr_q,     dsr_d;      // divisor magnitude
    logic [WIDTH-1:0] numer_q,   numer_d;    // raw dividend for the zero-divisor result
    logic             qneg_q,    qneg_d;
    logic             rneg_q,    rneg_d;
    logic             dz_q,      dz_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
    logic [WIDTH-1:0] quot_q,    quot_d;
    logic [WIDTH-1:0] rem_q,     rem_d;
    logic             divzero_q, divzero_d;

    logic [WIDTH:0]   shift_s;
    logic [WIDTH+1:0] trial_s;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and trial-subtract the divisor. The extra top bit of trial_s
    // is the borrow that tells whether the subtraction went negative.
    always_comb begin
        shift_s = {prem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
        trial_s = {1'b0, shift_s} - {2'b00, dsr_q};
    end

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        prem_d    = prem_q;
        dvd_d     = dvd_q;
        dsr_d     = dsr_q;
        numer_d   = numer_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        dz_d      = dz_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        quot_d    = quot_q;
        rem_d     = rem_q;
        divzero_d = divzero_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    numer_d = bus.numer;
                    rneg_d  = bus.numer[WIDTH-1];
                    qneg_d  = bus.numer[WIDTH-1] ^ bus.denom[WIDTH-1];
                    dz_d    = (bus.denom == {WIDTH{1'b0}});
                    dvd_d   = abs_val(bus.numer);
                    dsr_d   = abs_val(bus.denom);
                    prem_d  = {(WIDTH+1){1'b0}};
                    cnt_d   = CW'(WIDTH - 1);
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                busy_d = 1'b1;
                if (trial_s[WIDTH+1]) begin
                    prem_d = shift_s;
                    dvd_d  = {dvd_q[WIDTH-2:0], 1'b0};
                end else begin
                    prem_d = trial_s[WIDTH:0];
                    dvd_d  = {dvd_q[WIDTH-2:0], 1'b1};
                end
                if (cnt_q == {CW{1'b0}}) begin
                    state_d = ST_FIX;
                end else begin
                    cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
                end
            end
            ST_FIX: begin
                done_d    = 1'b1;
                divzero_d = dz_q;
                // A zero divisor runs the loop for fixed latency only; its
                // result is forced rather than taken from the loop.
                if (dz_q) begin
                    quot_d = {WIDTH{1'b1}};
                    rem_d  = numer_q;
                end else begin
                    quot_d = neg_if(qneg_q, dvd_q);
                    rem_d  = neg_if(rneg_q, prem_q[WIDTH-1:0]);
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= {CW{1'b0}};
            prem_q    <= {(WIDTH+1){1'b0}};
            dvd_q     <= {WIDTH{1'b0}};
            dsr_q     <= {WIDTH{1'b0}};
            numer_q   <= {WIDTH{1'b0}};
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            dz_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            quot_q    <= {WIDTH{1'b0}};
            rem_q     <= {WIDTH{1'b0}};
            divzero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prem_q    <= prem_d;
            dvd_q     <= dvd_d;
            dsr_q     <= dsr_d;
            numer_q   <= numer_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
            dz_q      <= dz_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            divzero_q <= divzero_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.quotient = quot_q;
    assign bus.remain   = rem_q;
    assign bus.divzero  = divzero_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: self-checking bench for seq_divider (WIDTH=16).
// Directed vector table, randomized operations against an arithmetic
// reference model, and hand-written sequences for start-while-busy,
// start-in-DONE, reset mid-operation and reset with start.
module tb_seq_divider;
    localparam int W = 16;

    typedef struct {
        logic [W-1:0] n;
        logic [W-1:0] d;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } vec_t;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_fail;

    seq_divider_if #(.WIDTH(W)) bus ();

    seq_divider #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference: plain signed arithmetic on wide integers. Truncating the
    // 32-bit result reproduces the most-negative / -1 wrap.
    task automatic ref_div(input logic [W-1:0] n, input logic [W-1:0] d,
                           output logic [W-1:0] q, output logic [W-1:0] r,
                           output logic dz);
        int ni;
        int di;
        ni = $signed(n);
        di = $signed(d);
        if (di == 0) begin
            q  = {W{1'b1}};
            r  = n;
            dz = 1'b1;
        end else begin
            q  = W'(ni / di);
            r  = W'(ni % di);
            dz = 1'b0;
        end
    endtask

    // Full operation from an IDLE cycle, checking busy/done each cycle and
    // the results in the done cycle; returns in the following IDLE cycle.
    task automatic do_op(input logic [W-1:0] n, input logic [W-1:0] d,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic edz);
        bus.numer = n;
        bus.denom = d;
        bus.start = 1'b1;
        for (int k = 1; k <= W + 2; k++) begin
            tick();
            if (k == 1) begin
                bus.start = 1'b0;
                bus.numer = 16'h5A5A;
                bus.denom = 16'h0003;
            end
            check("busy", 32'(bus.busy), 32'(k <= W + 1));
            check("done", 32'(bus.done), 32'(k == W + 2));
        end
        check("quotient", 32'(bus.quotient), 32'(eq));
        check("remain",   32'(bus.remain),   32'(er));
        check("divzero",  32'(bus.divzero),  32'(edz));
        tick();
        check("done_after", 32'(bus.done), 32'd0);
        check("busy_after", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        vec_t         vecs[$];
        logic [W-1:0] rn, rd, rq, rr;
        logic         rdz;

        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.numer = 16'h0000;
        bus.denom = 16'h0000;

        vecs.push_back('{16'd100,  16'd7,    16'd14,   16'd2,    1'b0});
        vecs.push_back('{16'hFF9C, 16'd7,    16'hFFF2, 16'hFFFE, 1'b0});
        vecs.push_back('{16'd100,  16'hFFF9, 16'hFFF2, 16'd2,    1'b0});
        vecs.push_back('{16'hFF9C, 16'hFFF9, 16'd14,   16'hFFFE, 1'b0});
        vecs.push_back('{16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0});
        vecs.push_back('{16'h8000, 16'h0001, 16'h8000, 16'h0000, 1'b0});
        vecs.push_back('{16'd1234, 16'h0000, 16'hFFFF, 16'd1234, 1'b1});
        vecs.push_back('{16'd9,    16'd3,    16'd3,    16'd0,    1'b0});
        vecs.push_back('{16'd0,    16'd5,    16'd0,    16'd0,    1'b0});
        vecs.push_back('{16'h7FFF, 16'h8000, 16'h0000, 16'h7FFF, 1'b0});
        vecs.push_back('{16'h8000, 16'h8000, 16'h0001, 16'h0000, 1'b0});
        vecs.push_back('{16'hFFFF, 16'd2,    16'h0000, 16'hFFFF, 1'b0});
        vecs.push_back('{16'h8000, 16'h0000, 16'hFFFF, 16'h8000, 1'b1});
        vecs.push_back('{16'd65535 >> 1, 16'd1, 16'h7FFF, 16'h0000, 1'b0});

        // Reset state
        tick();
        tick();
        check("rst_busy",     32'(bus.busy),     32'd0);
        check("rst_done",     32'(bus.done),     32'd0);
        check("rst_quotient", 32'(bus.quotient), 32'd0);
        check("rst_remain",   32'(bus.remain),   32'd0);
        check("rst_divzero",  32'(bus.divzero),  32'd0);
        reset = 1'b0;
        tick();

        // Directed table
        foreach (vecs[i]) begin
            do_op(vecs[i].n, vecs[i].d, vecs[i].q, vecs[i].r, vecs[i].dz);
        end

        // start while busy ignored; start in DONE ignored, accepted next cycle
        for (int k = 0; k <= 38; k++) begin
            if (k > 0) begin
                check("seq_busy", 32'(bus.busy), 32'((k >= 1 && k <= 17) || (k >= 20 && k <= 36)));
                check("seq_done", 32'(bus.done), 32'(k == 18 || k == 37));
                if (k == 18) begin
                    check("seq_q1", 32'(bus.quotient), 32'd10);
                    check("seq_r1", 32'(bus.remain),   32'd0);
                end
                if (k == 37) begin
                    check("seq_q2", 32'(bus.quotient), 32'd3);
                    check("seq_r2", 32'(bus.remain),   32'd1);
                end
            end
            case (k)
                0:       begin bus.start = 1'b1; bus.numer = 16'd50; bus.denom = 16'd5; end
                5:       begin bus.start = 1'b1; bus.numer = 16'd99; bus.denom = 16'd9; end
                18, 19:  begin bus.start = 1'b1; bus.numer = 16'd7;  bus.denom = 16'd2; end
                default: begin bus.start = 1'b0; bus.numer = 16'hAAAA; bus.denom = 16'h0000; end
            endcase
            tick();
        end

        // Reset in cycle 8 of an operation aborts it
        do_op(16'd100, 16'd7, 16'd14, 16'd2, 1'b0);
        bus.numer = 16'd200;
        bus.denom = 16'd3;
        bus.start = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            bus.start = 1'b0;
            check("abort_busy", 32'(bus.busy), 32'd1);
            check("abort_done", 32'(bus.done), 32'd0);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy9",     32'(bus.busy),     32'd0);
        check("abort_done9",     32'(bus.done),     32'd0);
        check("abort_quotient9", 32'(bus.quotient), 32'd0);
        check("abort_remain9",   32'(bus.remain),   32'd0);
        check("abort_divzero9",  32'(bus.divzero),  32'd0);
        for (int k = 10; k <= 30; k++) begin
            tick();
            check("abort_nodone", 32'(bus.done), 32'd0);
            check("abort_nobusy", 32'(bus.busy), 32'd0);
        end
        do_op(16'd200, 16'd3, 16'd66, 16'd2, 1'b0);

        // Reset and start together: request dropped
        reset     = 1'b1;
        bus.start = 1'b1;
        bus.numer = 16'd77;
        bus.denom = 16'd7;
        tick();
        reset     = 1'b0;
        bus.start = 1'b0;
        check("rststart_busy", 32'(bus.busy), 32'd0);
        for (int k = 0; k < 20; k++) begin
            tick();
            check("rststart_nobusy", 32'(bus.busy), 32'd0);
            check("rststart_nodone", 32'(bus.done), 32'd0);
        end

        // Randomized operations against the reference model
        for (int i = 0; i < 300; i++) begin
            rn = W'($urandom);
            rd = W'($urandom);
            case ($urandom_range(0, 7))
                0:       rd = 16'h0000;
                1:       rd = 16'hFFFF;
                2:       rn = 16'h8000;
                3:       rd = W'($urandom_range(1, 20));
                4:       rd = 16'h0000 - W'($urandom_range(1, 20));
                default: rd = rd;
            endcase
            ref_div(rn, rd, rq, rr, rdz);
            do_op(rn, rd, rq, rr, rdz);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/seq_divider.md
# seq_divider

Multi-cycle signed integer divider that serves as the responder for the ALU's divide operation (`s = 2'b11`). It accepts a numerator/denominator pair on a start strobe and runs a restoring shift-subtract loop, one quotient bit per clock. It returns quotient and remainder with a one-cycle done pulse. It replaces the free-running clock-enabled divider with an explicit start/busy/done handshake, so the control unit can stall deterministically on DIV.

## Interface
- `WIDTH`, default 16: operand and result width in bits; minimum 2.

- `clock`  in  1  single system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request strobe; sampled only in IDLE.
- `numer`  in  WIDTH  signed dividend, two's complement; sampled with `start`.
- `denom`  in  WIDTH  signed divisor, two's complement; sampled with `start`.
- `busy`  out  1  high while an operation is in progress.
- `done`  out  1  one-cycle pulse; results are valid from this cycle onward.
- `quotient`  out  WIDTH  signed quotient, truncated toward zero.
- `remain`  out  WIDTH  signed remainder; its sign follows `numer`, or it is zero.
- `divzero`  out  1  set with `done` when `denom` was 0; held until the next completion.

## Operation
- States are IDLE, RUN, FIX and DONE. On reset, state = IDLE.
- IDLE, `start=1`:
  - Latch sign(numer), sign(numer) XOR sign(denom), `denom==0`, |numer| and |denom|, each magnitude WIDTH bits unsigned.
  - Clear the partial remainder (WIDTH+1 bits).
  - Set the iteration counter to WIDTH-1 and go to RUN.
- IDLE, `start=0`: stay in IDLE.
- RUN, each cycle:
  - Shift {partial remainder, dividend magnitude} left one bit.
  - Trial-subtract |denom|.
  - If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - After the step with counter = 0, go to FIX; otherwise decrement the counter.
- FIX:
  - Negate the quotient magnitude if the signs differed.
  - Negate the remainder magnitude if numer was negative.
  - Register the results into `quotient` and `remain`, and go to DONE.
- Divide by zero:
  - The loop runs unchanged, so latency stays fixed.
  - FIX forces `quotient` = all ones (-1), `remain` = `numer` as latched, and `divzero` = 1.
- Overflow: most-negative / -1 wraps to `quotient` = most-negative (0x8000 for WIDTH=16) and `remain` = 0, with no flag. The magnitude path is unsigned WIDTH bits, so |0x8000| = 0x8000 is exact.
- DONE:
  - `done` = 1 for exactly this cycle, then go to IDLE.
  - `start` is not accepted in DONE; it is accepted from the following IDLE cycle.
- `start` while `busy` = 1 is ignored; the latched operands are unaffected.
- `numer`/`denom` may change freely after the start cycle.
- `quotient`, `remain` and `divzero` hold their values until the next FIX. `divzero` is updated (set or cleared) at every FIX.

## Timing
- Cycle 0 is the cycle in which `start` is high in IDLE.
- `busy` = 1 in cycles 1 .. WIDTH+1 (RUN and FIX); 0 in IDLE and DONE.
- `done` = 1 in cycle WIDTH+2 only. With WIDTH=16, `done` is in cycle 18, giving a fixed latency of WIDTH+2 clocks.
- The earliest next accepted `start` is in cycle WIDTH+3. Back-to-back throughput is one operation per WIDTH+3 cycles.
- Reset values: `busy` = 0, `done` = 0, `quotient` = 0, `remain` = 0, `divzero` = 0, state IDLE.
- Reset asserted mid-operation (any state) aborts the operation. No `done` is produced, and all outputs take their reset values on the next edge.
- `reset` and `start` in the same cycle: reset wins and the request is dropped.

## Test plan
- 100 / 7, `start` in cycle 0 -> `done` only in cycle 18; `quotient` = 14, `remain` = 2, `divzero` = 0; `busy` high in cycles 1–17.
- Sign combinations -100/7, 100/-7, -100/-7 -> (-14,-2), (-14,2), (14,-2) respectively.
- 0x8000 / 0xFFFF -> `quotient` = 0x8000, `remain` = 0; and 0x8000 / 1 -> 0x8000, 0.
- 1234 / 0 -> `done` in cycle 18 with `quotient` = 0xFFFF, `remain` = 1234, `divzero` = 1. A following 9/3 -> 3, 0 with `divzero` cleared.
- 50/5 started, then `start` with 99/9 in cycle 5 -> ignored; result 10, 0. A new `start` in the DONE cycle is ignored; the same `start` in cycle 19 is accepted, giving `done` in cycle 37.
- Reset asserted in cycle 8 of an operation -> no `done` ever pulses for it. All outputs are 0 from cycle 9, and the next `start` completes with normal latency.
